decode: RTL and testbench

- Decode stage; sits directly downstream of the fetch stage.
- Consumes raw 32-bit RV32I instructions over a valid/ready handshake and tracks the PC of each accepted instruction.
- Decodes fields and immediates; registers the result in a one-entry output slot that feeds exec.
- Flushes on a jump/branch redirect from exec; flags illegal instructions as a trap.

---
 rtl/decode_pkg.sv | 51 +++++
 rtl/decode_instr_decoder.sv | 68 ++++++
 rtl/decode.sv | 104 ++++++++++
 tb/tb_decode.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// Shared types for the decode stage: instruction classes, RV32I opcodes,
// the decode->exec slot payload and the illegal-instruction trap record.
package decode_pkg;

  typedef enum logic [3:0] {
    LUI     = 4'd0,
    AUIPC   = 4'd1,
    JAL     = 4'd2,
    JALR    = 4'd3,
    BRANCH  = 4'd4,
    LOAD    = 4'd5,
    STORE   = 4'd6,
    OP_IMM  = 4'd7,
    OP      = 4'd8,
    FENCE   = 4'd9,
    SYSTEM  = 4'd10,
    ILLEGAL = 4'd11
  } instr_class_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef struct packed {
    logic [31:0]  pc;
    instr_class_t cls;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic         rd_we;
    logic [2:0]   funct3;
    logic         funct7b5;
    logic [31:0]  imm;
    logic [31:0]  instr;
  } s_id_ex_t;

  typedef struct packed {
    logic        active;
    logic [31:0] pc_addr;
    logic [31:0] mtval;
  } s_trap_info_t;

endpackage

// File: rtl/decode_instr_decoder.sv
// Purely combinational RV32I field/immediate decoder; the pc field of the
// result is left zero and filled in by the caller.
module instr_decoder
  import decode_pkg::*;
(
  input  logic [31:0] instr_i,
  output s_id_ex_t    dec_o
);

  instr_class_t cls;

  always_comb begin
    cls = ILLEGAL;
    if (instr_i[1:0] == 2'b11) begin
      case (instr_i[6:0])
        OPC_LUI:    cls = LUI;
        OPC_AUIPC:  cls = AUIPC;
        OPC_JAL:    cls = JAL;
        OPC_JALR:   cls = JALR;
        OPC_BRANCH: cls = BRANCH;
        OPC_LOAD:   cls = LOAD;
        OPC_STORE:  cls = STORE;
        OPC_OP_IMM: cls = OP_IMM;
        OPC_OP:     cls = OP;
        OPC_FENCE:  cls = FENCE;
        OPC_SYSTEM: cls = SYSTEM;
        default:    cls = ILLEGAL;
      endcase
    end
  end

  always_comb begin
    dec_o          = '0;
    dec_o.cls      = cls;
    dec_o.instr    = instr_i;
    dec_o.rs1      = instr_i[19:15];
    dec_o.rs2      = instr_i[24:20];
    dec_o.rd       = instr_i[11:7];
    dec_o.funct3   = instr_i[14:12];
    dec_o.funct7b5 = instr_i[30];

    case (cls)
      JALR, LOAD, OP_IMM:
        dec_o.imm = {{20{instr_i[31]}}, instr_i[31:20]};
      STORE:
        dec_o.imm = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      BRANCH:
        dec_o.imm = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                     instr_i[30:25], instr_i[11:8], 1'b0};
      LUI, AUIPC:
        dec_o.imm = {instr_i[31:12], 12'h000};
      JAL:
        dec_o.imm = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                     instr_i[20], instr_i[30:21], 1'b0};
      default:
        dec_o.imm = 32'h0;
    endcase

    // Writes to x0 are architecturally discarded, so never request them.
    case (cls)
      LUI, AUIPC, JAL, JALR, LOAD, OP_IMM, OP, SYSTEM:
        dec_o.rd_we = (instr_i[11:7] != 5'd0);
      default:
        dec_o.rd_we = 1'b0;
    endcase
  end

endmodule

// File: rtl/decode.sv
// Decode stage: fetch handshake, PC tracker and a one-entry decoded slot
// feeding exec, with redirect flush and illegal-instruction trap reporting.
module decode
  import decode_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         fetch_start_i,
  input  logic [31:0]  fetch_start_addr_i,
  input  logic         fetch_valid_i,
  output logic         fetch_ready_o,
  input  logic [31:0]  fetch_instr_i,
  input  logic         jump_i,
  input  logic [31:0]  jump_addr_i,
  output logic         id_valid_o,
  input  logic         id_ready_i,
  output logic [31:0]  id_pc_o,
  output logic [3:0]   id_class_o,
  output logic [4:0]   id_rs1_o,
  output logic [4:0]   id_rs2_o,
  output logic [4:0]   id_rd_o,
  output logic         id_rd_we_o,
  output logic [2:0]   id_funct3_o,
  output logic         id_funct7b5_o,
  output logic [31:0]  id_imm_o,
  output s_trap_info_t trap_info_o
);

  logic [31:0] pc_q, pc_d;
  logic        start_q, start_d;
  logic        out_valid_q, out_valid_d;
  s_id_ex_t    slot_q, slot_d;
  s_id_ex_t    dec;
  logic        accept;
  logic        start_rise;
  logic        trap_active;
  logic        unused_jump_lsb;

  instr_decoder u_instr_decoder (
    .instr_i (fetch_instr_i),
    .dec_o   (dec)
  );

  assign fetch_ready_o   = ~jump_i & (~out_valid_q | id_ready_i);
  assign accept          = fetch_valid_i & fetch_ready_o;
  assign start_rise      = fetch_start_i & ~start_q;
  assign unused_jump_lsb = ^jump_addr_i[1:0];

  always_comb begin
    pc_d        = pc_q;
    start_d     = fetch_start_i;
    out_valid_d = out_valid_q;
    slot_d      = slot_q;
    // A boot request outranks a coincident redirect.
    if (start_rise) begin
      pc_d        = fetch_start_addr_i;
      out_valid_d = 1'b0;
    end else if (jump_i) begin
      pc_d        = {jump_addr_i[31:2], 2'b00};
      out_valid_d = 1'b0;
    end else if (accept) begin
      slot_d      = dec;
      slot_d.pc   = pc_q;
      out_valid_d = 1'b1;
      pc_d        = pc_q + 32'd4;
    end else if (id_ready_i && out_valid_q) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= RESET_PC;
      start_q     <= 1'b0;
      out_valid_q <= 1'b0;
      slot_q      <= '0;
    end else begin
      pc_q        <= pc_d;
      start_q     <= start_d;
      out_valid_q <= out_valid_d;
      slot_q      <= slot_d;
    end
  end

  assign id_valid_o    = out_valid_q;
  assign id_pc_o       = slot_q.pc;
  assign id_class_o    = slot_q.cls;
  assign id_rs1_o      = slot_q.rs1;
  assign id_rs2_o      = slot_q.rs2;
  assign id_rd_o       = slot_q.rd;
  assign id_rd_we_o    = slot_q.rd_we;
  assign id_funct3_o   = slot_q.funct3;
  assign id_funct7b5_o = slot_q.funct7b5;
  assign id_imm_o      = slot_q.imm;

  // Trap fields read as zero whenever no illegal instruction occupies the slot.
  assign trap_active         = out_valid_q && (slot_q.cls == ILLEGAL);
  assign trap_info_o.active  = trap_active;
  assign trap_info_o.pc_addr = trap_active ? slot_q.pc : 32'h0;
  assign trap_info_o.mtval   = trap_active ? slot_q.instr : 32'h0;

endmodule

// File: tb/tb_decode.sv
// Scoreboard bench for the decode stage: directed instructions push expected
// slot contents, a monitor pops and compares on every exec consume.
module tb_decode;
  import decode_pkg::*;

  logic         clk;
  logic         rst;
  logic         fetch_start_i;
  logic [31:0]  fetch_start_addr_i;
  logic         fetch_valid_i;
  logic         fetch_ready_o;
  logic [31:0]  fetch_instr_i;
  logic         jump_i;
  logic [31:0]  jump_addr_i;
  logic         id_valid_o;
  logic         id_ready_i;
  logic [31:0]  id_pc_o;
  logic [3:0]   id_class_o;
  logic [4:0]   id_rs1_o, id_rs2_o, id_rd_o;
  logic         id_rd_we_o;
  logic [2:0]   id_funct3_o;
  logic         id_funct7b5_o;
  logic [31:0]  id_imm_o;
  s_trap_info_t trap_info_o;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rd_we;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] imm;
    logic [31:0] instr;
    logic        trap;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  decode #(.RESET_PC(32'h0000_0000)) dut (
    .clk                (clk),
    .rst                (rst),
    .fetch_start_i      (fetch_start_i),
    .fetch_start_addr_i (fetch_start_addr_i),
    .fetch_valid_i      (fetch_valid_i),
    .fetch_ready_o      (fetch_ready_o),
    .fetch_instr_i      (fetch_instr_i),
    .jump_i             (jump_i),
    .jump_addr_i        (jump_addr_i),
    .id_valid_o         (id_valid_o),
    .id_ready_i         (id_ready_i),
    .id_pc_o            (id_pc_o),
    .id_class_o         (id_class_o),
    .id_rs1_o           (id_rs1_o),
    .id_rs2_o           (id_rs2_o),
    .id_rd_o            (id_rd_o),
    .id_rd_we_o         (id_rd_we_o),
    .id_funct3_o        (id_funct3_o),
    .id_funct7b5_o      (id_funct7b5_o),
    .id_imm_o           (id_imm_o),
    .trap_info_o        (trap_info_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [3:0] cls,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic rd_we,
                              input logic [2:0] f3, input logic f7b5,
                              input logic [31:0] imm, input logic [31:0] instr);
    exp_t e;
    e.pc = pc; e.cls = cls; e.rs1 = rs1; e.rs2 = rs2; e.rd = rd;
    e.rd_we = rd_we; e.f3 = f3; e.f7b5 = f7b5; e.imm = imm; e.instr = instr;
    e.trap = (cls == 4'(ILLEGAL));
    return e;
  endfunction

  // Present one instruction and push its expectation in the cycle it is accepted.
  task automatic send(input logic [31:0] instr, input exp_t e);
    bit accepted = 0;
    fetch_valid_i = 1'b1;
    fetch_instr_i = instr;
    for (int i = 0; i < 20 && !accepted; i++) begin
      @(negedge clk);
      if (fetch_ready_o) begin
        sb_q.push_back(e);
        accepted = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!accepted) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: instr %h never accepted", instr);
    end
    fetch_valid_i = 1'b0;
    $display("send instr=%h pc=%h accepted=%0d", instr, e.pc, accepted);
  endtask

  task automatic drain();
    bit done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d outstanding expected 0", sb_q.size());
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && id_valid_o && id_ready_i) begin
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: pc %h expected none", id_pc_o);
        end else begin
          e = sb_q.pop_front();
          $display("consume pc=%h class=%0d rd=%0d imm=%h", id_pc_o, id_class_o, id_rd_o, id_imm_o);
          chk("pc", id_pc_o, e.pc);
          chk("class", 32'(id_class_o), 32'(e.cls));
          chk("rs1", 32'(id_rs1_o), 32'(e.rs1));
          chk("rs2", 32'(id_rs2_o), 32'(e.rs2));
          chk("rd", 32'(id_rd_o), 32'(e.rd));
          chk("rd_we", 32'(id_rd_we_o), 32'(e.rd_we));
          chk("funct3", 32'(id_funct3_o), 32'(e.f3));
          chk("funct7b5", 32'(id_funct7b5_o), 32'(e.f7b5));
          chk("imm", id_imm_o, e.imm);
          chk("trap_active", 32'(trap_info_o.active), 32'(e.trap));
          if (e.trap) begin
            chk("trap_pc", trap_info_o.pc_addr, e.pc);
            chk("trap_mtval", trap_info_o.mtval, e.instr);
          end
        end
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1;
    fetch_start_i = 1'b0;
    fetch_start_addr_i = 32'h0;
    fetch_valid_i = 1'b0;
    fetch_instr_i = 32'h0;
    jump_i = 1'b0;
    jump_addr_i = 32'h0;
    id_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 32'(id_valid_o), 32'd0);
    chk("rst_pc", id_pc_o, 32'h0);
    chk("rst_imm", id_imm_o, 32'h0);
    chk("rst_trap", 32'(trap_info_o.active), 32'd0);
    chk("rst_ready", 32'(fetch_ready_o), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Boot and stream two instructions back to back.
    fetch_start_i = 1'b1;
    fetch_start_addr_i = 32'h8000_0000;
    @(posedge clk); #1;
    send(32'h00500093, mk(32'h8000_0000, 4'(OP_IMM), 5'd0, 5'd5, 5'd1, 1'b1, 3'd0, 1'b0, 32'd5, 32'h00500093));
    send(32'h00208133, mk(32'h8000_0004, 4'(OP), 5'd1, 5'd2, 5'd2, 1'b1, 3'd0, 1'b0, 32'd0, 32'h00208133));
    drain();

    // Backpressure: slot holds ADDI x0 while the BEQ waits.
    id_ready_i = 1'b0;
    send(32'h00000013, mk(32'h8000_0008, 4'(OP_IMM), 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 32'd0, 32'h00000013));
    fetch_valid_i = 1'b1;
    fetch_instr_i = 32'hFE000EE3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_ready", 32'(fetch_ready_o), 32'd0);
      chk("bp_valid", 32'(id_valid_o), 32'd1);
      chk("bp_pc", id_pc_o, 32'h8000_0008);
      @(posedge clk); #1;
    end
    id_ready_i = 1'b1;
    send(32'hFE000EE3, mk(32'h8000_000C, 4'(BRANCH), 5'd0, 5'd0, 5'd29, 1'b0, 3'd0, 1'b1, 32'hFFFF_FFFC, 32'hFE000EE3));
    send(32'h800000EF, mk(32'h8000_0010, 4'(JAL), 5'd0, 5'd0, 5'd1, 1'b1, 3'd0, 1'b0, 32'hFFF0_0000, 32'h800000EF));
    drain();

    // Redirect while the slot is occupied.
    id_ready_i = 1'b0;
    send(32'h00500093, mk(32'h8000_0014, 4'(OP_IMM), 5'd0, 5'd5, 5'd1, 1'b1, 3'd0, 1'b0, 32'd5, 32'h00500093));
    jump_i = 1'b1;
    jump_addr_i = 32'h0000_1003;
    fetch_valid_i = 1'b1;
    fetch_instr_i = 32'h00208133;
    @(negedge clk);
    chk("jump_ready", 32'(fetch_ready_o), 32'd0);
    @(posedge clk); #1;
    jump_i = 1'b0;
    fetch_valid_i = 1'b0;
    void'(sb_q.pop_back());
    @(negedge clk);
    chk("jump_flush", 32'(id_valid_o), 32'd0);
    id_ready_i = 1'b1;
    @(posedge clk); #1;
    send(32'h00208133, mk(32'h0000_1000, 4'(OP), 5'd1, 5'd2, 5'd2, 1'b1, 3'd0, 1'b0, 32'd0, 32'h00208133));
    drain();

    // Illegal instruction at PC 0x10.
    jump_i = 1'b1;
    jump_addr_i = 32'h0000_0010;
    @(posedge clk); #1;
    jump_i = 1'b0;
    send(32'hFFFF_FFFF, mk(32'h0000_0010, 4'(ILLEGAL), 5'd31, 5'd31, 5'd31, 1'b0, 3'd7, 1'b1, 32'd0, 32'hFFFF_FFFF));
    drain();
    @(negedge clk);
    chk("trap_clear", 32'(trap_info_o.active), 32'd0);
    @(posedge clk); #1;

    // Start and jump together: start wins.
    fetch_start_i = 1'b0;
    @(posedge clk); #1;
    fetch_start_i = 1'b1;
    fetch_start_addr_i = 32'h0000_0100;
    jump_i = 1'b1;
    jump_addr_i = 32'h0000_0200;
    @(posedge clk); #1;
    jump_i = 1'b0;
    fetch_start_i = 1'b0;
    send(32'h00000013, mk(32'h0000_0100, 4'(OP_IMM), 5'd0, 5'd0, 5'd0, 1'b0, 3'd0, 1'b0, 32'd0, 32'h00000013));
    drain();

    // Reset mid-stream discards the slot and restores RESET_PC.
    id_ready_i = 1'b0;
    send(32'h00500093, mk(32'h0000_0104, 4'(OP_IMM), 5'd0, 5'd5, 5'd1, 1'b1, 3'd0, 1'b0, 32'd5, 32'h00500093));
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_valid", 32'(id_valid_o), 32'd0);
    chk("midrst_pc", id_pc_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    void'(sb_q.pop_back());
    id_ready_i = 1'b1;
    send(32'h00208133, mk(32'h0000_0000, 4'(OP), 5'd1, 5'd2, 5'd2, 1'b1, 3'd0, 1'b0, 32'd0, 32'h00208133));
    drain();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
